ir_line_tracker: RTL and testbench

// - Consumes the five IR line-sensor bits (L, LC, C, RC, R) from the IR sensor pass-through stage.
// - Synchronises and debounces each bit, encodes a signed line position and tracks line state in an FSM:

---
 rtl/ir_line_pkg.sv | 50 +++++
 rtl/ir_debounce.sv | 40 ++++
 rtl/ir_line_tracker.sv | 137 +++++++++++++
 tb/tb_ir_line_tracker.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_line_pkg.sv
// ir_line_pkg: shared types and constants for the IR line tracker.
// FSM states, sensor bit indices, position weights and small helpers.
package ir_line_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRACK,
    CROSS,
    LOST_WAIT,
    LOST
  } lineState_t;

  localparam int BitL  = 4;
  localparam int BitLC = 3;
  localparam int BitC  = 2;
  localparam int BitRC = 1;
  localparam int BitR  = 0;

  localparam logic [4:0] MaskL  = 5'b1 << BitL;
  localparam logic [4:0] MaskLC = 5'b1 << BitLC;
  localparam logic [4:0] MaskC  = 5'b1 << BitC;
  localparam logic [4:0] MaskRC = 5'b1 << BitRC;
  localparam logic [4:0] MaskR  = 5'b1 << BitR;

  localparam logic signed [3:0] WeightL  = -4'sd4;
  localparam logic signed [3:0] WeightLC = -4'sd2;
  localparam logic signed [3:0] WeightC  = 4'sd0;
  localparam logic signed [3:0] WeightRC = 4'sd2;
  localparam logic signed [3:0] WeightR  = 4'sd4;

  function automatic logic [2:0] popCount5(
    input logic [4:0] v
  );
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 5; i++) begin
      c = c + 3'(v[i]);
    end
    return c;
  endfunction

  // Pair sums stay within -6..6, so 4-bit math is exact.
  function automatic logic signed [3:0] midWeight(
    input logic signed [3:0] a,
    input logic signed [3:0] b
  );
    return (a + b) >>> 1;
  endfunction

endpackage

// File: rtl/ir_debounce.sv
// ir_debounce: one sensor bit, 2-FF synchroniser plus stability counter.
// The clean bit follows only after DEBOUNCE_CYCLES differing samples.
module ir_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rawBit,
  output logic cleanBit
);

  localparam int CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast =
    CntW'(DEBOUNCE_CYCLES - 1);

  logic sync1;
  logic sync2;
  logic [CntW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      cnt      <= '0;
      cleanBit <= 1'b0;
    end else begin
      sync1 <= rawBit;
      sync2 <= sync1;
      if (sync2 == cleanBit) begin
        cnt <= '0;
      end else if (cnt == CntLast) begin
        cleanBit <= sync2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/ir_line_tracker.sv
// ir_line_tracker: debounced IR sensors to line position and line state.
// Define IR_TRACKER_IRQ_EN to build the sticky irq flag.
module ir_line_tracker
  import ir_line_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int LOST_TIMEOUT    = 100000,
  parameter int CROSS_MIN       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] sens_raw,
  output logic [4:0] sens_clean,
  output logic [3:0] position,
  output logic       line_valid,
  output logic       crossing,
  output logic       line_lost,
  output logic [7:0] cross_count,
  output logic       irq,
  input  logic       irq_clr
);

  localparam int TimerW = $clog2(LOST_TIMEOUT);
  localparam logic [TimerW-1:0] TimerLast =
    TimerW'(LOST_TIMEOUT - 1);
  localparam logic [2:0] CrossMin = 3'(CROSS_MIN);

  lineState_t state;
  lineState_t nextState;
  logic [TimerW-1:0] lostTimer;
  logic [2:0] nActive;
  logic signed [3:0] posNext;
  logic posHit;
  logic enterCross;

  for (genvar i = 0; i < 5; i++) begin : gDeb
    ir_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uDeb (
      .clk     (clk),
      .rst_n   (rst_n),
      .rawBit  (sens_raw[i]),
      .cleanBit(sens_clean[i])
    );
  end

  assign nActive = popCount5(sens_clean);

  always_comb begin
    posHit  = 1'b1;
    posNext = WeightC;
    unique case (sens_clean)
      MaskL:           posNext = WeightL;
      MaskLC:          posNext = WeightLC;
      MaskC:           posNext = WeightC;
      MaskRC:          posNext = WeightRC;
      MaskR:           posNext = WeightR;
      MaskL  | MaskLC: posNext = midWeight(WeightL, WeightLC);
      MaskLC | MaskC:  posNext = midWeight(WeightLC, WeightC);
      MaskC  | MaskRC: posNext = midWeight(WeightC, WeightRC);
      MaskRC | MaskR:  posNext = midWeight(WeightRC, WeightR);
      default:         posHit  = 1'b0;
    endcase
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE, LOST: begin
        if (nActive >= CrossMin) nextState = CROSS;
        else if (nActive != 0)   nextState = TRACK;
      end
      TRACK: begin
        if (nActive >= CrossMin) nextState = CROSS;
        else if (nActive == 0)   nextState = LOST_WAIT;
      end
      CROSS: begin
        if (nActive == 0)            nextState = LOST_WAIT;
        else if (nActive < CrossMin) nextState = TRACK;
      end
      LOST_WAIT: begin
        // A returning line beats a timeout on the same cycle.
        if (nActive >= CrossMin)       nextState = CROSS;
        else if (nActive != 0)         nextState = TRACK;
        else if (lostTimer == TimerLast) nextState = LOST;
      end
      default: nextState = IDLE;
    endcase
  end

  assign enterCross = (nextState == CROSS) && (state != CROSS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lostTimer   <= '0;
      position    <= '0;
      cross_count <= '0;
    end else begin
      state     <= nextState;
      lostTimer <= (state == LOST_WAIT) ?
                   lostTimer + TimerW'(1) : '0;
      if ((state == TRACK) && posHit) position <= posNext;
      if (enterCross) cross_count <= cross_count + 8'd1;
    end
  end

  assign line_valid = (state == TRACK) || (state == CROSS) ||
                      (state == LOST_WAIT);
  assign crossing   = (state == CROSS);
  assign line_lost  = (state == LOST);

`ifdef IR_TRACKER_IRQ_EN
  logic irqFlag;
  logic irqSet;

  assign irqSet = (nextState != state) &&
                  ((nextState == CROSS) || (nextState == LOST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irqFlag <= 1'b0;
    end else if (irqSet) begin
      irqFlag <= 1'b1;
    end else if (irq_clr) begin
      irqFlag <= 1'b0;
    end
  end

  assign irq = irqFlag;
`else
  logic unusedIrqClr;
  assign unusedIrqClr = irq_clr;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_ir_line_tracker.sv
// tb_ir_line_tracker: directed scenarios plus random sensor traffic
// checked against a behavioural model of the line tracker.
module tb_ir_line_tracker;

  localparam int Deb      = 4;
  localparam int Tmo      = 16;
  localparam int CrossMin = 4;

  localparam int SIdle  = 0;
  localparam int STrack = 1;
  localparam int SCross = 2;
  localparam int SWait  = 3;
  localparam int SLost  = 4;

`ifdef IR_TRACKER_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] sens_raw;
  logic [4:0] sens_clean;
  logic [3:0] position;
  logic       line_valid;
  logic       crossing;
  logic       line_lost;
  logic [7:0] cross_count;
  logic       irq;
  logic       irq_clr;

  always #5 clk = ~clk;

  ir_line_tracker #(
    .DEBOUNCE_CYCLES(Deb),
    .LOST_TIMEOUT   (Tmo),
    .CROSS_MIN      (CrossMin)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sens_raw   (sens_raw),
    .sens_clean (sens_clean),
    .position   (position),
    .line_valid (line_valid),
    .crossing   (crossing),
    .line_lost  (line_lost),
    .cross_count(cross_count),
    .irq        (irq),
    .irq_clr    (irq_clr)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state
  logic [4:0] mS1, mS2, mClean;
  logic [4:0] hist [Deb];
  int mState, mWait, mPos, mCross;
  logic mIrq;

  function automatic int posOf(logic [4:0] v, int cur);
    int idx[$];
    for (int b = 0; b < 5; b++) if (v[b]) idx.push_back(b);
    if (idx.size() == 1) return 2 * (2 - idx[0]);
    if (idx.size() == 2 && idx[1] - idx[0] == 1)
      return (2 * (2 - idx[0]) + 2 * (2 - idx[1])) / 2;
    return cur;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int n;
    int nxt;
    bit flip;
    if (!rst_n) begin
      mS1 = '0; mS2 = '0; mClean = '0;
      for (int k = 0; k < Deb; k++) hist[k] = '0;
      mState = SIdle; mWait = 0; mPos = 0;
      mCross = 0; mIrq = 1'b0;
    end else begin
      n = $countones(mClean);
      if (mState == STrack) mPos = posOf(mClean, mPos);
      nxt = mState;
      case (mState)
        STrack:
          if (n >= CrossMin) nxt = SCross;
          else if (n == 0) nxt = SWait;
        SCross:
          if (n == 0) nxt = SWait;
          else if (n < CrossMin) nxt = STrack;
        SWait:
          if (n > 0) nxt = (n >= CrossMin) ? SCross : STrack;
          else if (mWait == Tmo - 1) nxt = SLost;
        default:
          if (n > 0) nxt = (n >= CrossMin) ? SCross : STrack;
      endcase
      mWait = (mState == SWait && nxt == SWait) ? mWait + 1 : 0;
      if (nxt == SCross && mState != SCross)
        mCross = (mCross + 1) % 256;
      if (IrqEn) begin
        if (nxt != mState && (nxt == SCross || nxt == SLost))
          mIrq = 1'b1;
        else if (irq_clr)
          mIrq = 1'b0;
      end
      mState = nxt;
      // A clean bit flips once the last Deb synced samples all disagree
      for (int k = 0; k < Deb - 1; k++) hist[k] = hist[k + 1];
      hist[Deb - 1] = mS2;
      for (int b = 0; b < 5; b++) begin
        flip = 1'b1;
        for (int k = 0; k < Deb; k++)
          if (hist[k][b] == mClean[b]) flip = 1'b0;
        if (flip) mClean[b] = ~mClean[b];
      end
      mS2 = mS1;
      mS1 = sens_raw;
    end
  end

  logic [20:0] dutVec;
  logic [20:0] expVec;

  assign dutVec = {sens_clean, position, line_valid, crossing,
                   line_lost, cross_count, irq};

  always_comb begin
    expVec = {mClean, 4'(mPos),
              (mState == STrack || mState == SCross || mState == SWait),
              (mState == SCross), (mState == SLost),
              8'(mCross), mIrq};
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sens_raw = '0;
    irq_clr = 1'b0;
    tick(3);
    nChecks++;
    if (dutVec !== 21'd0) begin
      nFails++;
      $display("FAIL reset_state: got %h want 0", dutVec);
    end
    sens_raw = 5'b00100;
    rst_n = 1'b1;
    tick(5);
    nChecks++;
    if (sens_clean !== 5'b00000) begin
      nFails++;
      $display("FAIL reset_lat5: sens_clean %b want 00000", sens_clean);
    end
    tick(1);
    nChecks++;
    if (sens_clean !== 5'b00100) begin
      nFails++;
      $display("FAIL reset_lat6: sens_clean %b want 00100", sens_clean);
    end
    tick(2);
    nChecks++;
    if (line_valid !== 1'b1 || crossing !== 1'b0 ||
        position !== 4'h0) begin
      nFails++;
      $display("FAIL reset_track: valid %b cross %b pos %h want 1 0 0",
               line_valid, crossing, position);
    end
    nChecks++;
    if (dutVec !== expVec) begin
      nFails++;
      $display("FAIL reset_model: got %h want %h", dutVec, expVec);
    end
  endtask

  task automatic test_glitch();
    sens_raw = 5'b10100;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) sens_raw = 5'b00100;
      tick(1);
      nChecks++;
      if (sens_clean[4] !== 1'b0 || position !== 4'h0) begin
        nFails++;
        $display("FAIL glitch: clean %b pos %h want bit4=0 pos 0",
                 sens_clean, position);
      end
    end
  endtask

  task automatic test_position();
    sens_raw = 5'b01100;
    tick(12);
    nChecks++;
    if (position !== 4'hF) begin
      nFails++;
      $display("FAIL pos_m1: got %h want f", position);
    end
    sens_raw = 5'b00011;
    tick(12);
    nChecks++;
    if (position !== 4'h3) begin
      nFails++;
      $display("FAIL pos_p3: got %h want 3", position);
    end
    nChecks++;
    if (dutVec !== expVec) begin
      nFails++;
      $display("FAIL pos_model: got %h want %h", dutVec, expVec);
    end
  endtask

  task automatic test_crossing();
    sens_raw = 5'b11110;
    tick(10);
    nChecks++;
    if (crossing !== 1'b1 || cross_count !== 8'd1 ||
        line_valid !== 1'b1 || position !== 4'h3) begin
      nFails++;
      $display("FAIL cross1: cross %b cnt %0d valid %b pos %h want 1 1 1 3",
               crossing, cross_count, line_valid, position);
    end
    nChecks++;
    if (irq !== IrqEn) begin
      nFails++;
      $display("FAIL cross1_irq: got %b want %b", irq, IrqEn);
    end
    irq_clr = 1'b1;
    tick(1);
    irq_clr = 1'b0;
    nChecks++;
    if (irq !== 1'b0) begin
      nFails++;
      $display("FAIL irq_clear: got %b want 0", irq);
    end
    sens_raw = 5'b00100;
    tick(10);
    nChecks++;
    if (crossing !== 1'b0 || line_valid !== 1'b1) begin
      nFails++;
      $display("FAIL cross_exit: cross %b valid %b want 0 1",
               crossing, line_valid);
    end
    sens_raw = 5'b11110;
    tick(6);
    irq_clr = 1'b1;
    tick(1);
    irq_clr = 1'b0;
    nChecks++;
    if (crossing !== 1'b1 || cross_count !== 8'd2) begin
      nFails++;
      $display("FAIL cross2: cross %b cnt %0d want 1 2",
               crossing, cross_count);
    end
    nChecks++;
    if (irq !== IrqEn) begin
      nFails++;
      $display("FAIL irq_set_prio: got %b want %b", irq, IrqEn);
    end
  endtask

  task automatic test_lost();
    sens_raw = 5'b01000;
    tick(12);
    nChecks++;
    if (position !== 4'hE) begin
      nFails++;
      $display("FAIL lost_pre_pos: got %h want e", position);
    end
    sens_raw = 5'b00000;
    for (int i = 1; i <= 22; i++) begin
      irq_clr = (i == 2);
      tick(1);
      nChecks++;
      if (line_valid !== 1'b1 || line_lost !== 1'b0) begin
        nFails++;
        $display("FAIL lost_wait c%0d: valid %b lost %b want 1 0",
                 i, line_valid, line_lost);
      end
    end
    nChecks++;
    if (irq !== 1'b0) begin
      nFails++;
      $display("FAIL lost_irq_pre: got %b want 0", irq);
    end
    tick(1);
    nChecks++;
    if (line_lost !== 1'b1 || line_valid !== 1'b0 ||
        position !== 4'hE) begin
      nFails++;
      $display("FAIL lost: lost %b valid %b pos %h want 1 0 e",
               line_lost, line_valid, position);
    end
    nChecks++;
    if (irq !== IrqEn) begin
      nFails++;
      $display("FAIL lost_irq: got %b want %b", irq, IrqEn);
    end
  endtask

  task automatic test_lost_recover();
    sens_raw = 5'b00100;
    tick(10);
    nChecks++;
    if (line_valid !== 1'b1 || line_lost !== 1'b0) begin
      nFails++;
      $display("FAIL relock: valid %b lost %b want 1 0",
               line_valid, line_lost);
    end
    sens_raw = 5'b00000;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (i == 16) sens_raw = 5'b00100;
      nChecks++;
      if (line_lost !== 1'b0) begin
        nFails++;
        $display("FAIL race c%0d: lost %b want 0", i, line_lost);
      end
      if (i == 23) begin
        nChecks++;
        if (line_valid !== 1'b1 || crossing !== 1'b0) begin
          nFails++;
          $display("FAIL race_track: valid %b cross %b want 1 0",
                   line_valid, crossing);
        end
      end
    end
    nChecks++;
    if (dutVec !== expVec) begin
      nFails++;
      $display("FAIL race_model: got %h want %h", dutVec, expVec);
    end
  endtask

  task automatic test_reset_mid();
    sens_raw = 5'b11110;
    tick(10);
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (dutVec !== 21'd0) begin
      nFails++;
      $display("FAIL reset_mid_async: got %h want 0", dutVec);
    end
    tick(2);
    rst_n = 1'b1;
    tick(3);
    nChecks++;
    if (dutVec !== expVec || cross_count !== 8'd0) begin
      nFails++;
      $display("FAIL reset_mid_post: got %h want %h", dutVec, expVec);
    end
  endtask

  task automatic test_random();
    int cyc;
    int len;
    logic [4:0] pat;
    cyc = 0;
    while (cyc < 3000) begin
      case ($urandom_range(0, 5))
        0:       pat = 5'b0;
        1, 2:    pat = 5'(1 << $urandom_range(0, 4));
        3:       pat = 5'(3 << $urandom_range(0, 3));
        default: pat = 5'($urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 4);
      else len = $urandom_range(5, 30);
      if (pat == 5'b0 && $urandom_range(0, 1) == 1)
        len = $urandom_range(20, 40);
      sens_raw = pat;
      for (int i = 0; i < len; i++) begin
        irq_clr = ($urandom_range(0, 7) == 0);
        tick(1);
        cyc++;
        nChecks++;
        if (dutVec !== expVec) begin
          nFails++;
          $display("FAIL random c%0d: got %h want %h",
                   cyc, dutVec, expVec);
        end
      end
    end
    irq_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_position();
    test_crossing();
    test_lost();
    test_lost_recover();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
